// File: rtl/riscv_run_pkg.sv
// Shared FSM encoding, default parameters and counter-width helper for the run monitor.
// Build option RUN_MON_CHGCNT_EN is consumed by riscv_run_monitor, not here.
package riscv_run_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_RESET_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN        = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE       = ST_IDLE,
        S_RESET_HOLD = ST_RESET_HOLD,
        S_RUN        = ST_RUN,
        S_DONE       = ST_DONE
    } run_state_t;

    localparam int DEF_DATA_W        = 32;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_RST_CYCLES    = 3;
    localparam int DEF_STABLE_CYCLES = 8;
    localparam int DEF_MAX_CYCLES    = 1000;

    // Bits needed to hold the value n itself; never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/run_mon_stable_cnt.sv
// Saturating count of consecutive matching cycles; reached is a same-cycle lookahead,
// so the owner can act on the edge where the count becomes STABLE_CYCLES.
module run_mon_stable_cnt
    import riscv_run_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic match,
    output logic reached
);

    localparam int             SW     = cnt_width(STABLE_CYCLES);
    localparam logic [SW-1:0]  TGT    = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0]  TGT_M1 = SW'(STABLE_CYCLES - 1);

    logic [SW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (!match) begin
            cnt <= '0;
        end else if (cnt != TGT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign reached = match && (cnt >= TGT_M1);

endmodule

// File: rtl/riscv_run_monitor.sv
// Core run controller: reset hold, cycle count, signature-stable PASS or budget TIMEOUT.
// Optional RUN_MON_CHGCNT_EN adds CHG_CNT (RUN cycles where OBS changed).
module riscv_run_monitor
    import riscv_run_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_CYCLES    = DEF_MAX_CYCLES
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] EXP_SIG,
    input  logic [DATA_W-1:0] OBS,
    output logic              CORE_RST_N,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic              TIMEOUT,
    output logic [CNT_W-1:0]  CYCLES,
`ifdef RUN_MON_CHGCNT_EN
    output logic [CNT_W-1:0]  CHG_CNT,
`endif
    output logic [DATA_W-1:0] LAST_OBS
);

    localparam int             HW        = cnt_width(RST_CYCLES);
    localparam logic [HW-1:0]  HOLD_LOAD = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

    run_state_t        state;
    run_state_t        state_nxt;
    logic [HW-1:0]     hold_cnt;
    logic [DATA_W-1:0] sig;
    logic              start_acc;
    logic              match;
    logic              stable_reached;
    logic              timeout_hit;

    assign match       = (state == S_RUN) && (OBS == sig);
    assign timeout_hit = (state == S_RUN) && (CYCLES == LAST_CYC);

    run_mon_stable_cnt #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_stable (
        .clk    (CLK),
        .rst    (RST),
        .clear  (start_acc),
        .match  (match),
        .reached(stable_reached)
    );

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    start_acc = 1'b1;
                    state_nxt = S_RESET_HOLD;
                end
            end
            S_RESET_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stable_reached || timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            sig      <= '0;
            CYCLES   <= '0;
            PASS     <= 1'b0;
            TIMEOUT  <= 1'b0;
            LAST_OBS <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                sig      <= EXP_SIG;
                CYCLES   <= '0;
                PASS     <= 1'b0;
                TIMEOUT  <= 1'b0;
                hold_cnt <= HOLD_LOAD;
            end else if (state == S_RESET_HOLD) begin
                if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end else if (state == S_RUN) begin
                CYCLES   <= CYCLES + 1'b1;
                LAST_OBS <= OBS;
                // A signature that settles on the final budget cycle still counts as PASS.
                if (stable_reached) begin
                    PASS <= 1'b1;
                end else if (timeout_hit) begin
                    TIMEOUT <= 1'b1;
                end
            end
        end
    end

`ifdef RUN_MON_CHGCNT_EN
    always_ff @(posedge CLK) begin
        if (RST || start_acc) begin
            CHG_CNT <= '0;
        end else if ((state == S_RUN) && (OBS != LAST_OBS)) begin
            CHG_CNT <= CHG_CNT + 1'b1;
        end
    end
`endif

    assign BUSY       = (state == S_RESET_HOLD) || (state == S_RUN);
    assign DONE       = (state == S_DONE);
    assign CORE_RST_N = (state == S_RUN) || (state == S_DONE);

endmodule
